// File: rtl/i2c_pkg.sv
// Shared I2C target types and constants.
package i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h3C;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    REG_HI,
    ACK_HI,
    REG_LO,
    ACK_LO,
    WR_DATA,
    ACK_WR,
    RD_DATA,
    RD_ACK
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP condition detection.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Synchronizer chains plus one-cycle-delayed copies; idle bus level is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SDA moving while SCL is steadily high marks a bus condition.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_register_target.sv
// I2C target exposing a 16-bit register address space with auto-increment.
module i2c_register_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEVICE_ADDR = I2C_DEFAULT_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl_io,
  inout  wire         sda_io,
  output logic [15:0] reg_addr_o,
  output logic [7:0]  reg_data_o,
  output logic        write_valid_o,
  input  logic [7:0]  read_data_i,
  output logic        read_strobe_o,
  output logic        busy_o
);

  i2c_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wv_q, wv_d;
  logic        rs_q, rs_d;
  logic        sda_low_q, sda_low_d;
  logic        busy_q, busy_d;
  logic        rw_q, rw_d;

  logic sda_s, scl_rise, scl_fall, start_c, stop_c;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clock),
    .rst_i      (reset),
    .scl_i      (scl_io),
    .sda_i      (sda_io),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_c),
    .stop_o     (stop_c)
  );

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      hi_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wv_q      <= 1'b0;
      rs_q      <= 1'b0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wv_q      <= wv_d;
      rs_q      <= rs_d;
      sda_low_q <= sda_low_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
    end
  end

  // Next-state logic: bits in on SCL rise, SDA drive changes only after SCL fall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wv_d      = 1'b0;
    rs_d      = 1'b0;
    sda_low_d = sda_low_q;
    busy_d    = busy_q;
    rw_d      = rw_q;

    // Address advances the cycle after a write pulse so the pulse shows the written address.
    if (wv_q) addr_d = addr_q + 16'd1;
    // The strobe cycle is the capture cycle; reg_addr_o already points at the byte to read.
    if (rs_q) shift_d = read_data_i;

    if (stop_c) begin
      state_d   = IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_c) begin
      state_d   = DEV_ADDR;
      cnt_d     = '0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        DEV_ADDR, REG_HI, REG_LO, WR_DATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d     = '0;
            sda_low_d = 1'b1;
            case (state_q)
              DEV_ADDR: begin
                if (shift_q[7:1] == DEVICE_ADDR) begin
                  state_d = DEV_ACK;
                  busy_d  = 1'b1;
                  rw_d    = shift_q[0];
                end else begin
                  state_d   = IDLE;
                  sda_low_d = 1'b0;
                  busy_d    = 1'b0;
                end
              end
              REG_HI: begin
                state_d = ACK_HI;
                hi_d    = shift_q;
              end
              REG_LO:  state_d = ACK_LO;
              default: state_d = ACK_WR;
            endcase
          end
        end
        DEV_ACK: begin
          if (scl_rise && rw_q) rs_d = 1'b1;
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d   = RD_DATA;
              sda_low_d = ~shift_q[7];
            end else begin
              state_d   = REG_HI;
              sda_low_d = 1'b0;
            end
          end
        end
        ACK_HI: begin
          if (scl_fall) begin
            state_d   = REG_LO;
            sda_low_d = 1'b0;
          end
        end
        ACK_LO: begin
          if (scl_fall) begin
            state_d   = WR_DATA;
            sda_low_d = 1'b0;
            addr_d    = {hi_q, shift_q};
          end
        end
        ACK_WR: begin
          if (scl_rise) begin
            data_d = shift_q;
            wv_d   = 1'b1;
          end else if (scl_fall) begin
            state_d   = WR_DATA;
            sda_low_d = 1'b0;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d   = RD_ACK;
              cnt_d     = '0;
              sda_low_d = 1'b0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_low_d = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          // A NACK leaves immediately; still being here at SCL fall means the byte was ACKed.
          if (scl_rise) begin
            if (!sda_s) begin
              rs_d   = 1'b1;
              addr_d = addr_q + 16'd1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall) begin
            state_d   = RD_DATA;
            sda_low_d = ~shift_q[7];
          end
        end
        default: begin
          state_d   = IDLE;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_io        = sda_low_q ? 1'b0 : 1'bz;
  assign reg_addr_o    = addr_q;
  assign reg_data_o    = data_q;
  assign write_valid_o = wv_q;
  assign read_strobe_o = rs_q;
  assign busy_o        = busy_q;

endmodule

// File: doc/i2c_register_target.md
I2C_REGISTER_TARGET -- requirements
Module: i2c_register_target

Interface
REQ-001 The block SHALL have parameter DEVICE_ADDR, default 7'h3C, the 7-bit I2C address the block answers to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on SCL and SDA (minimum 2).
REQ-003 The block SHALL have port clock  input  1  system clock; one clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port scl_io  input  1  I2C clock from the controller; the block never stretches it.
REQ-006 The block SHALL have port sda_io  inout  1  I2C data, open-drain: the block drives only 1'b0 or 1'bz.
REQ-007 The block SHALL have port reg_addr_o  output  16  register address of the current write or read byte.
REQ-008 The block SHALL have port reg_data_o  output  8  data byte received in a write.
REQ-009 The block SHALL have port write_valid_o  output  1  one-cycle pulse: reg_addr_o/reg_data_o hold a completed write.
REQ-010 The block SHALL have port read_data_i  input  8  byte to return for reg_addr_o during a read.
REQ-011 The block SHALL have port read_strobe_o  output  1  one-cycle pulse marking the cycle read_data_i is captured.
REQ-012 The block SHALL have port busy_o  output  1  high from an addressed START until STOP or NACK-abort.

Function
REQ-013 SCL and SDA SHALL pass through SYNC_STAGES flops; all decisions use synchronized values and their one-cycle-delayed copies.
REQ-014 START SHALL be SDA 1->0 while SCL high; STOP SHALL be SDA 0->1 while SCL high; both are recognized in any state.
REQ-015 Bits SHALL be sampled on a synchronized SCL rising edge, MSB first; the block SHALL change its SDA drive only on the cycle after a synchronized SCL falling edge.
REQ-016 States: IDLE, DEV_ADDR, DEV_ACK, REG_HI, ACK_HI, REG_LO, ACK_LO, WR_DATA, ACK_WR, RD_DATA, RD_ACK.
REQ-017 START (including repeated START) SHALL enter DEV_ADDR with the bit counter cleared; STOP SHALL enter IDLE and release SDA.
REQ-018 DEV_ADDR SHALL shift 8 bits; on a 7-bit address mismatch the block SHALL leave SDA released (NACK) and go to IDLE.
REQ-019 On a match with R/W=0 the block SHALL ACK (drive SDA low for the 9th SCL pulse) and proceed to REG_HI.
REQ-020 REG_HI then REG_LO SHALL each shift 8 bits, ACK each, and load reg_addr_o = {hi, lo} at the end of ACK_LO.
REQ-021 Each WR_DATA byte SHALL be ACKed, loaded into reg_data_o, and pulse write_valid_o exactly once on the SCL rising edge of the ACK bit.
REQ-022 After each write pulse reg_addr_o SHALL increment by 1, wrapping 16'hFFFF -> 16'h0000; further bytes continue in WR_DATA.
REQ-023 On a match with R/W=1 the block SHALL ACK, pulse read_strobe_o, capture read_data_i into a shift register, and shift it out in RD_DATA.
REQ-024 In RD_ACK a controller ACK (SDA low) SHALL increment reg_addr_o (with wrap), strobe, reload, and return to RD_DATA; a NACK SHALL go to IDLE with SDA released.
REQ-025 A read with no preceding register-address write SHALL use the current reg_addr_o.
REQ-026 START or STOP mid-byte SHALL abort the partial byte with no write_valid_o pulse; reg_addr_o is unchanged unless ACK_LO completed.
REQ-027 Simultaneous START and STOP detection is impossible; STOP takes priority in the same cycle if a glitch produces both.
REQ-028 write_valid_o and read_strobe_o SHALL never be high in the same cycle.

Reset
REQ-029 On reset: state IDLE, SDA released, reg_addr_o=16'h0000, reg_data_o=8'h00, write_valid_o=0, read_strobe_o=0, busy_o=0, synchronizers=1.
REQ-030 Reset mid-transaction SHALL release SDA on the next clock and ignore the bus until the next START.

Structure
REQ-031 A shared package i2c_pkg SHALL hold the state enum type and constant I2C_DEFAULT_ADDR = 7'h3C.
REQ-032 Synchronizer plus edge/START/STOP detection SHALL be sub-module i2c_line_sync.

Verification
REQ-033 Write 0x3C(W), 0x30, 0x08, 0x82, STOP -> four ACKs; one write_valid_o pulse with reg_addr_o=16'h3008, reg_data_o=8'h82.
REQ-034 Address 0x21(W), 0x30 -> SDA never driven low; no pulses; busy_o stays 0.
REQ-035 Write 0x3C(W), 0xFF, 0xFF, 0x11, 0x22 -> pulses (16'hFFFF, 8'h11) then (16'h0000, 8'h22).
REQ-036 Write 0x3C(W), 0x30, 0x0A, repeated START, 0x3C(R), read_data_i=8'h56 -> SDA bits 01010110; controller NACK -> IDLE, SDA released.
REQ-037 STOP after 4 bits of a data byte -> no write_valid_o pulse; next full write succeeds normally.
REQ-038 reset asserted during REG_LO ACK -> SDA released next cycle, all outputs at reset values.
